// File: rtl/vram_writer.sv
// Producer side of the RGB VRAMs: executes pixel and filled-rectangle commands,
// issuing one write per granted cycle in raster order on a shared address/data bus.
module vram_writer #(
    parameter int unsigned H_PIX  = 128,
    parameter int unsigned V_PIX  = 96,
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [6:0]        cmd_x0,
    input  logic [6:0]        cmd_x1,
    input  logic [6:0]        cmd_y0,
    input  logic [6:0]        cmd_y1,
    input  logic [2:0]        cmd_rgb,
    input  logic              vram_gnt,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_di_red,
    output logic              vram_di_green,
    output logic              vram_di_blue,
    output logic              vram_we,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned X_W = $clog2(H_PIX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q;
    logic              op_q;
    logic [6:0]        x0_q, x1_q, y0_q, y1_q;
    logic [6:0]        cur_x_q, cur_y_q;
    logic [2:0]        rgb_q;
    logic [ADDR_W-1:0] addr_q;

    logic [6:0]        x0_d, x1_d, y0_d, y1_d;
    logic              bad_d;
    logic              last_px;
    logic [ADDR_W-1:0] wrap_step;

    function automatic logic [6:0] clamp(input logic [6:0] v, input logic [7:0] lim);
        return ({1'b0, v} >= lim) ? 7'(lim - 8'd1) : v;
    endfunction

    function automatic logic [ADDR_W-1:0] to_addr(input logic [6:0] y, input logic [6:0] x);
        return (ADDR_W'(y) << X_W) | ADDR_W'(x);
    endfunction

    always_comb begin
        x0_d      = clamp(x0_q, 8'(H_PIX));
        y0_d      = clamp(y0_q, 8'(V_PIX));
        x1_d      = clamp(op_q ? x1_q : x0_q, 8'(H_PIX));
        y1_d      = clamp(op_q ? y1_q : y0_q, 8'(V_PIX));
        bad_d     = (x0_d > x1_d) || (y0_d > y1_d);
        last_px   = (cur_x_q == x1_q) && (cur_y_q == y1_q);
        // Row wrap jumps from (x1,y) to (x0,y+1) without a multiplier.
        wrap_step = ADDR_W'(H_PIX) - ADDR_W'(x1_q - x0_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            x0_q    <= '0;
            x1_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            cur_x_q <= '0;
            cur_y_q <= '0;
            rgb_q   <= '0;
            addr_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_op;
                        x0_q    <= cmd_x0;
                        x1_q    <= cmd_x1;
                        y0_q    <= cmd_y0;
                        y1_q    <= cmd_y1;
                        rgb_q   <= cmd_rgb;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    x0_q <= x0_d;
                    x1_q <= x1_d;
                    y0_q <= y0_d;
                    y1_q <= y1_d;
                    if (bad_d) begin
                        state_q <= S_ERR;
                    end else begin
                        cur_x_q <= x0_d;
                        cur_y_q <= y0_d;
                        addr_q  <= to_addr(y0_d, x0_d);
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (vram_gnt) begin
                        if (last_px) begin
                            state_q <= S_DONE;
                        end else if (cur_x_q < x1_q) begin
                            cur_x_q <= cur_x_q + 7'd1;
                            addr_q  <= addr_q + ADDR_W'(1);
                        end else begin
                            cur_x_q <= x0_q;
                            cur_y_q <= cur_y_q + 7'd1;
                            addr_q  <= addr_q + wrap_step;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                S_ERR:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready     = (state_q == S_IDLE) && !reset;
    assign vram_we       = (state_q == S_WRITE) && vram_gnt && !reset;
    assign vram_addr     = addr_q;
    assign vram_di_red   = rgb_q[2];
    assign vram_di_green = rgb_q[1];
    assign vram_di_blue  = rgb_q[0];
    assign busy          = (state_q == S_LOAD) || (state_q == S_WRITE);
    assign done          = (state_q == S_DONE);
    assign err           = (state_q == S_ERR);

endmodule

// File: tb/tb_vram_writer.sv
// Self-checking bench for vram_writer: directed scenarios plus randomized commands
// and grant patterns compared against a list-of-pixels reference model.
module tb_vram_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [6:0]  cmd_x0, cmd_x1, cmd_y0, cmd_y1;
    logic [2:0]  cmd_rgb;
    logic        vram_gnt;
    logic [13:0] vram_addr;
    logic        vram_di_red, vram_di_green, vram_di_blue;
    logic        vram_we;
    logic        busy, done, err;

    vram_writer #(.H_PIX(128), .V_PIX(96), .ADDR_W(14)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
        .cmd_rgb(cmd_rgb), .vram_gnt(vram_gnt), .vram_addr(vram_addr),
        .vram_di_red(vram_di_red), .vram_di_green(vram_di_green), .vram_di_blue(vram_di_blue),
        .vram_we(vram_we), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // reference model output
    int exp_addr[$];
    logic exp_err;

    // observations from the last command
    int obs_addr[$];
    logic obs_done, obs_err, obs_timeout;
    int di_bad, hold_bad, first_k, done_k;

    function automatic int clampv(input int v, input int lim);
        return (v >= lim) ? lim - 1 : v;
    endfunction

    task automatic build_model(input logic op, input int x0, input int y0,
                               input int x1, input int y1);
        int ax0, ay0, ax1, ay1;
        exp_addr.delete();
        ax0 = clampv(x0, 128);
        ay0 = clampv(y0, 96);
        ax1 = clampv(op ? x1 : x0, 128);
        ay1 = clampv(op ? y1 : y0, 96);
        exp_err = (ax0 > ax1) || (ay0 > ay1);
        if (!exp_err)
            for (int y = ay0; y <= ay1; y++)
                for (int x = ax0; x <= ax1; x++)
                    exp_addr.push_back(y * 128 + x);
    endtask

    function automatic int addr_mismatches();
        int m = 0;
        if (obs_addr.size() != exp_addr.size()) m++;
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++)
            if (obs_addr[i] != exp_addr[i]) m++;
        return m;
    endfunction

    // gmode: 0 = always granted, 1 = repeating 1,0,0 pattern, 2 = random
    task automatic run_cmd(input logic op, input int x0, input int y0, input int x1,
                           input int y1, input logic [2:0] rgb, input int gmode,
                           input int abort_after);
        int cnt, limit;
        logic finished;
        build_model(op, x0, y0, x1, y1);
        obs_addr.delete();
        obs_done = 0; obs_err = 0; obs_timeout = 0;
        di_bad = 0; hold_bad = 0; first_k = -1; done_k = -1;
        finished = 0;
        cnt = 0;
        @(negedge clk);
        while (!cmd_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        cmd_op = op;
        cmd_x0 = 7'(x0); cmd_y0 = 7'(y0); cmd_x1 = 7'(x1); cmd_y1 = 7'(y1);
        cmd_rgb = rgb;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        limit = exp_addr.size() * 4 + 50;
        for (int k = 0; k < limit; k++) begin
            case (gmode)
                0:       vram_gnt = 1'b1;
                1:       vram_gnt = (k % 3 == 1);
                default: vram_gnt = ($urandom_range(0, 2) != 0);
            endcase
            @(negedge clk);
            if (vram_we) begin
                if (first_k < 0) first_k = k;
                obs_addr.push_back(int'(vram_addr));
                if ({vram_di_red, vram_di_green, vram_di_blue} !== rgb) di_bad++;
                if (abort_after > 0 && obs_addr.size() == abort_after) return;
            end else if (busy && !vram_gnt && obs_addr.size() > 0 &&
                         obs_addr.size() < exp_addr.size()) begin
                if (int'(vram_addr) != exp_addr[obs_addr.size()]) hold_bad++;
            end
            if (done) begin obs_done = 1; done_k = k; finished = 1; break; end
            if (err) begin obs_err = 1; finished = 1; break; end
            @(posedge clk);
            #1;
        end
        if (!finished) obs_timeout = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; vram_gnt = 1'b0; cmd_op = 1'b0;
        cmd_x0 = '0; cmd_x1 = '0; cmd_y0 = '0; cmd_y1 = '0; cmd_rgb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++;
        if (cmd_ready !== 1'b0) $display("FAIL reset_ready_low: got %b want 0", cmd_ready);
        else n_pass++;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_total++;
        if ({cmd_ready, busy, done, err, vram_we} !== 5'b10000)
            $display("FAIL reset_ctrl: got ready/busy/done/err/we=%b want 10000",
                     {cmd_ready, busy, done, err, vram_we});
        else n_pass++;
        n_total++;
        if ({vram_addr, vram_di_red, vram_di_green, vram_di_blue} !== 17'd0)
            $display("FAIL reset_bus: got addr=%0d di=%b%b%b want 0/000",
                     vram_addr, vram_di_red, vram_di_green, vram_di_blue);
        else n_pass++;
    endtask

    task automatic test_pixel();
        run_cmd(1'b0, 0, 1, 99, 99, 3'b100, 0, 0);
        n_total++;
        if (obs_addr.size() != 1 || obs_addr[0] != 128)
            $display("FAIL pixel_write: got %0d writes first=%0d want 1 at 128",
                     obs_addr.size(), obs_addr.size() > 0 ? obs_addr[0] : -1);
        else n_pass++;
        n_total++;
        if (di_bad != 0) $display("FAIL pixel_di: got %0d bad di cycles want 0", di_bad);
        else n_pass++;
        n_total++;
        if (first_k != 1) $display("FAIL pixel_latency: got first write at %0d want 1", first_k);
        else n_pass++;
        n_total++;
        if (!obs_done || done_k != first_k + 1)
            $display("FAIL pixel_done: got done=%b at %0d want 1 at %0d", obs_done, done_k, first_k + 1);
        else n_pass++;
    endtask

    task automatic test_rect_row();
        run_cmd(1'b1, 112, 49, 127, 49, 3'b111, 0, 0);
        n_total++;
        if (addr_mismatches() != 0 || obs_addr.size() != 16)
            $display("FAIL row_addrs: got %0d writes (%0d mismatches) want 16 at 6384..6399",
                     obs_addr.size(), addr_mismatches());
        else n_pass++;
        n_total++;
        if (!obs_done || di_bad != 0)
            $display("FAIL row_done_di: got done=%b di_bad=%0d want 1/0", obs_done, di_bad);
        else n_pass++;
    endtask

    task automatic test_stall();
        int want[$] = '{386, 387, 388, 514, 515, 516};
        int m = 0;
        run_cmd(1'b1, 2, 3, 4, 4, 3'b010, 1, 0);
        if (obs_addr.size() != 6) m++;
        for (int i = 0; i < 6 && i < obs_addr.size(); i++) if (obs_addr[i] != want[i]) m++;
        n_total++;
        if (m != 0) $display("FAIL stall_addrs: got %0d writes %0d mismatches want 6/0", obs_addr.size(), m);
        else n_pass++;
        n_total++;
        if (hold_bad != 0) $display("FAIL stall_hold: got %0d moved-address stalls want 0", hold_bad);
        else n_pass++;
        n_total++;
        if (!obs_done) $display("FAIL stall_done: got %b want 1", obs_done);
        else n_pass++;
    endtask

    task automatic test_err();
        run_cmd(1'b1, 10, 5, 5, 6, 3'b001, 0, 0);
        n_total++;
        if (!obs_err || obs_done || obs_addr.size() != 0)
            $display("FAIL err_reject: got err=%b done=%b writes=%0d want 1/0/0",
                     obs_err, obs_done, obs_addr.size());
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (cmd_ready !== 1'b1 || err !== 1'b0)
            $display("FAIL err_idle: got ready=%b err=%b want 1/0", cmd_ready, err);
        else n_pass++;
    endtask

    task automatic test_clamp();
        run_cmd(1'b1, 0, 90, 1, 120, 3'b011, 0, 0);
        n_total++;
        if (obs_addr.size() != 12 || obs_addr[obs_addr.size() - 1] != 12161)
            $display("FAIL clamp_y: got %0d writes last=%0d want 12 last 12161",
                     obs_addr.size(), obs_addr.size() > 0 ? obs_addr[obs_addr.size() - 1] : -1);
        else n_pass++;
        n_total++;
        if (addr_mismatches() != 0) $display("FAIL clamp_seq: got %0d mismatches want 0", addr_mismatches());
        else n_pass++;
    endtask

    task automatic test_random();
        int x0, y0, x1, y1, m;
        logic op;
        for (int i = 0; i < 25; i++) begin
            op = 1'($urandom_range(0, 3) != 0);
            x0 = $urandom_range(0, 127);
            y0 = $urandom_range(0, 110);
            x1 = (x0 + $urandom_range(0, 10)) % 128;
            y1 = (y0 + $urandom_range(0, 5)) % 128;
            run_cmd(op, x0, y0, x1, y1, 3'($urandom_range(0, 7)), 2, 0);
            m = addr_mismatches();
            n_total++;
            if (obs_timeout || obs_err !== exp_err || obs_done === exp_err || m != 0 ||
                di_bad != 0 || hold_bad != 0)
                $display("FAIL random_cmd%0d: got err=%b done=%b to=%b mism=%0d di_bad=%0d hold_bad=%0d want err=%b",
                         i, obs_err, obs_done, obs_timeout, m, di_bad, hold_bad, exp_err);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_fill();
        run_cmd(1'b1, 0, 0, 127, 95, 3'b101, 0, 100);
        n_total++;
        if (obs_addr.size() != 100) $display("FAIL abort_pre: got %0d writes want 100", obs_addr.size());
        else n_pass++;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        n_total++;
        if (vram_we !== 1'b0) $display("FAIL abort_we: got %b want 0", vram_we);
        else n_pass++;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_total++;
        if ({cmd_ready, done, busy, vram_we} !== 4'b1000)
            $display("FAIL abort_idle: got ready/done/busy/we=%b want 1000", {cmd_ready, done, busy, vram_we});
        else n_pass++;
        run_cmd(1'b1, 0, 0, 127, 95, 3'b110, 0, 0);
        n_total++;
        if (obs_addr.size() != 12288 || obs_addr[obs_addr.size() - 1] != 12287 || addr_mismatches() != 0)
            $display("FAIL full_fill: got %0d writes mism=%0d want 12288 last 12287",
                     obs_addr.size(), addr_mismatches());
        else n_pass++;
        n_total++;
        if (!obs_done) $display("FAIL full_done: got %b want 1", obs_done);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        run_cmd(1'b0, 5, 5, 0, 0, 3'b001, 0, 0);
        run_cmd(1'b1, 6, 6, 7, 6, 3'b010, 0, 0);
        n_total++;
        if (!obs_done || addr_mismatches() != 0 || first_k != 1)
            $display("FAIL back_to_back: got done=%b mism=%0d first=%0d want 1/0/1",
                     obs_done, addr_mismatches(), first_k);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_pixel();
        test_rect_row();
        test_stall();
        test_err();
        test_clamp();
        test_back_to_back();
        test_random();
        test_reset_mid_fill();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vram_writer.md
Name: vram_writer

Overview:
- Writes pixel colour data into the three 1-bit VRAMs (red, green, blue), the producer side of the VRAM that the VGA scan-out reads.
- Accepts single-pixel and filled-rectangle commands over a valid/ready handshake and issues one write per cycle on a shared address/DI/WE bus.
- Writes only while an external arbiter grants VRAM access (vram_gnt), so it never collides with scan-out reads.
- Frame is 128x96, 1 bit per colour, raster address = y*H_PIX + x.

Parameters:
- H_PIX, 128, horizontal pixels; power of two, address = {y, x}.
- V_PIX, 96, vertical pixels.
- ADDR_W, 14, VRAM address width; must satisfy H_PIX*V_PIX <= 2^ADDR_W.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  writer can accept a command.
- cmd_op  in  1  0 = single pixel at (x0,y0); 1 = filled rectangle (x0,y0)-(x1,y1) inclusive.
- cmd_x0, cmd_x1  in  7  column coordinates.
- cmd_y0, cmd_y1  in  7  row coordinates.
- cmd_rgb  in  3  colour {red, green, blue}.
- vram_gnt  in  1  arbiter grant; writes allowed in cycles where high.
- vram_addr  out  ADDR_W  VRAM address, shared by all three VRAMs.
- vram_di_red, vram_di_green, vram_di_blue  out  1  per-VRAM write data.
- vram_we  out  1  write enable, common to all three VRAMs.
- busy  out  1  high from command acceptance until done.
- done  out  1  one-cycle pulse after the last write of a command.
- err  out  1  one-cycle pulse when a command is rejected.

Behaviour:
- Reset values:
  - State IDLE; cmd_ready=1 on the cycle after reset deasserts.
  - busy=0, done=0, err=0, vram_we=0, vram_addr=0, all DI=0.
  - While reset is high, cmd_ready=0.
- FSM states: IDLE, LOAD, WRITE, DONE, ERR.
- IDLE:
  - cmd_ready=1.
  - Command is accepted at the edge where cmd_valid && cmd_ready; all cmd_* fields are latched at that edge. Go to LOAD.
- LOAD (1 cycle, busy=1, cmd_ready=0):
  - cmd_op=0 forces x1=x0 and y1=y0.
  - Any coordinate >= its limit is clamped: x to H_PIX-1, y to V_PIX-1.
  - If x0>x1 or y0>y1 after clamping, go to ERR.
  - Otherwise: cur_x=x0, cur_y=y0, vram_addr register = y0*H_PIX + x0. Go to WRITE.
- WRITE:
  - vram_we = vram_gnt, combinational from the grant; vram_we=0 in every other state.
  - vram_addr = cur_y*H_PIX + cur_x.
  - vram_di_* = latched rgb bits, held for the whole command.
  - At each edge where vram_we=1, the pixel is written and the position advances in raster order:
    - If cur_x<x1: cur_x+1.
    - Otherwise: cur_x=x0, cur_y+1.
    - If the written pixel was (x1,y1): go to DONE.
  - Address is updated incrementally: +1 within a row, +(H_PIX-(x1-x0)) on row wrap. No multiplier.
  - vram_gnt=0 stalls: addr and DI hold, no advance.
- DONE: 1 cycle; done=1, busy=0 that cycle. Go to IDLE.
- ERR: 1 cycle; err=1, no writes ever issued. Go to IDLE.
- Write count: exactly (x1-x0+1)*(y1-y0+1) cycles with vram_we=1 per command, each address written exactly once.
- Minimum latency: acceptance edge E0; LOAD in cycle E0..E1; first possible write in cycle E1..E2.
  - A back-to-back command is accepted no earlier than the edge ending the DONE/ERR cycle.
- Reset during WRITE: vram_we drops in the same cycle as reset. Next state IDLE; the remaining pixels are abandoned with no done pulse.
- A grant change mid-rectangle never skips or repeats a pixel.

Test Plan:
- Pixel op (x0=0, y0=1, rgb=100), vram_gnt=1 -> single vram_we cycle at vram_addr=128 with di_red=1, di_green=0, di_blue=0; done pulses the next cycle.
- Rect (x0=112, y0=49, x1=127, y1=49, rgb=111), gnt=1 -> 16 consecutive writes at addresses 6384..6399, all DI=1; then done.
- Rect (2,3)-(4,4), gnt toggling 1,0,0,1,... -> addresses 386, 387, 388, 514, 515, 516 in order; vram_addr held during gnt=0; exactly 6 we cycles.
- Rect x0=10, x1=5 -> err pulse, zero vram_we cycles, back to IDLE.
- Rect (0,90)-(1,120) -> y1 clamped to 95; 12 writes ending at address 12161.
- Full-screen fill (0,0)-(127,95): assert reset after 100 writes -> vram_we=0 from the reset cycle, no done, cmd_ready=1 after release. A fresh full fill then gives 12288 writes, last at address 12287.
